// File: rtl/modp_pow_if.sv
// modp_pow_if: request/response bundle for the modular exponentiation engine.
// The requester drives start/mode/x/e; the engine returns busy/done/result/err.
interface modp_pow_if #(
  parameter int unsigned N = 255,
  parameter int unsigned E = 255
);
  logic         start;
  logic         mode;
  logic [N-1:0] x;
  logic [E-1:0] e;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         err;

  modport master (
    output start, mode, x, e,
    input  busy, done, result, err
  );

  modport slave (
    input  start, mode, x, e,
    output busy, done, result, err
  );
endinterface

// File: rtl/modp_pow.sv
// modp_pow: x^e mod p with p = 2^N - C, MSB-first square-and-multiply built on
// an interleaved bit-serial modular multiplier (one multiplier bit per cycle).
// Build option MODP_POW_CT_EN: when defined the multiply pass runs for every
// exponent bit, giving data-independent latency 2 + 2*E*N; when undefined the
// multiply pass is skipped for zero exponent bits.
module modp_pow #(
  parameter int unsigned N = 255,
  parameter int unsigned C = 19,
  parameter int unsigned E = 255
) (
  input  logic      clk,
  input  logic      rst,
  modp_pow_if.slave bus
);

  localparam int unsigned NW   = N + 2;
  localparam int unsigned CntW = (E > 1) ? $clog2(E) : 1;
  localparam int unsigned McW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [NW-1:0] PExt   = (NW'(1) << N) - NW'(C);
  localparam logic [N-1:0]  P      = PExt[N-1:0];
  localparam logic [E-1:0]  ExpInv = E'(P - N'(2));

  typedef enum logic [2:0] {StIdle, StLoad, StSqr, StMul, StFin} state_e;

  state_e state_q, state_d;

  logic [N-1:0]    x_q, base_q, acc_q, acc_d;
  logic [E-1:0]    e_q, exp_q;
  logic            mode_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    a_q, b_q, t_q, t_d;
  logic [McW-1:0]  mc_q;
  logic [N-1:0]    result_q;
  logic            err_q, done_q, busy_q;

  logic cap_en, load_en, step_en, acc_we, op_ld, op_base, adv_en, fin_en;
  logic mul_last, last_bit;
  logic [NW-1:0] t2, s1, s2;
  logic unused_s2;

  assign mul_last = (mc_q == McW'(N - 1));
  assign last_bit = (cnt_q == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each multiply pass occupies exactly N cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.start) state_d = StLoad;
      StLoad: state_d = StSqr;
      StSqr: begin
        if (mul_last) begin
`ifdef MODP_POW_CT_EN
          state_d = StMul;
`else
          if (exp_q[E-1]) begin
            state_d = StMul;
          end else if (last_bit) begin
            state_d = StFin;
          end else begin
            state_d = StSqr;
          end
`endif
        end
      end
      StMul: if (mul_last) state_d = last_bit ? StFin : StSqr;
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: datapath enables and next accumulator value.
  always_comb begin
    cap_en  = 1'b0;
    load_en = 1'b0;
    step_en = 1'b0;
    acc_we  = 1'b0;
    op_ld   = 1'b0;
    op_base = 1'b0;
    adv_en  = 1'b0;
    fin_en  = 1'b0;
    case (state_q)
      StIdle: cap_en = bus.start;
      StLoad: begin
        load_en = 1'b1;
        op_ld   = 1'b1;
      end
      StSqr: begin
        step_en = 1'b1;
        if (mul_last) begin
          acc_we = 1'b1;
          if (state_d == StMul) begin
            op_ld   = 1'b1;
            op_base = 1'b1;
          end else if (state_d == StSqr) begin
            op_ld  = 1'b1;
            adv_en = 1'b1;
          end
        end
      end
      StMul: begin
        step_en = 1'b1;
        if (mul_last) begin
          // The product is always formed; it is kept only for a set bit.
          acc_we = exp_q[E-1];
          if (state_d == StSqr) begin
            op_ld  = 1'b1;
            adv_en = 1'b1;
          end
        end
      end
      StFin: fin_en = 1'b1;
      default: ;
    endcase
    acc_d = acc_q;
    if (load_en) begin
      acc_d = N'(1);
    end else if (acc_we) begin
      acc_d = t_d;
    end
  end

  // Multiplier step: t = 2t + (bit ? a : 0), then two conditional subtractions;
  // t < p and a < p bound the sum below 3p, so N+2 bits suffice.
  always_comb begin
    t2  = {1'b0, t_q, 1'b0} + (b_q[N-1] ? {2'b00, a_q} : '0);
    s1  = (t2 >= PExt) ? t2 - PExt : t2;
    s2  = (s1 >= PExt) ? s1 - PExt : s1;
    t_d = s2[N-1:0];
  end

  assign unused_s2 = ^s2[NW-1:N];

  // Datapath registers: operand capture, exponent scan, multiplier, results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      e_q      <= '0;
      mode_q   <= 1'b0;
      base_q   <= '0;
      acc_q    <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      mc_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (cap_en) begin
        x_q    <= bus.x;
        e_q    <= bus.e;
        mode_q <= bus.mode;
      end
      if (load_en) begin
        // x < 2^N < 2p, so a single subtraction fully reduces it.
        base_q <= (x_q >= P) ? x_q - P : x_q;
        exp_q  <= mode_q ? ExpInv : e_q;
        cnt_q  <= CntW'(E - 1);
      end
      acc_q <= acc_d;
      if (op_ld) begin
        a_q  <= acc_d;
        b_q  <= op_base ? base_q : acc_d;
        t_q  <= '0;
        mc_q <= '0;
      end else if (step_en) begin
        t_q  <= t_d;
        b_q  <= b_q << 1;
        mc_q <= mc_q + McW'(1);
      end
      if (adv_en) begin
        cnt_q <= cnt_q - CntW'(1);
        exp_q <= exp_q << 1;
      end
      if (fin_en) begin
        result_q <= acc_q;
        err_q    <= mode_q & (base_q == '0);
      end
      done_q <= fin_en;
      if (cap_en) begin
        busy_q <= 1'b1;
      end else if (fin_en) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_modp_pow.sv
// tb_modp_pow: directed vectors for p = 31 (N=5) and p = 251 (N=8), plus
// handshake, back-to-back and asynchronous reset sequences.
module tb_modp_pow;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

`ifdef MODP_POW_CT_EN
  localparam bit CtBuild = 1'b1;
`else
  localparam bit CtBuild = 1'b0;
`endif

  always #5 clk = ~clk;

  modp_pow_if #(.N(5), .E(5)) b5 ();
  modp_pow_if #(.N(8), .E(8)) b8 ();

  modp_pow #(.N(5), .C(1), .E(5)) u_dut5 (.clk(clk), .rst(rst), .bus(b5));
  modp_pow #(.N(8), .C(5), .E(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {
    logic       mode;
    logic [4:0] x;
    logic [4:0] e;
    logic [4:0] res;
    logic       err;
  } vec5_t;

  typedef struct {
    logic       mode;
    logic [7:0] x;
    logic [7:0] e;
    logic [7:0] res;
    logic       err;
  } vec8_t;

  vec5_t v5[14];
  vec8_t v8[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat_exp(input int n, input int ebits, input int pop);
    return 2 + ebits * n + n * (CtBuild ? ebits : pop);
  endfunction

  task automatic run5(input logic m, input logic [4:0] xv, input logic [4:0] ev,
                      output logic [4:0] r, output logic er, output int lat);
    @(negedge clk);
    b5.start = 1'b1;
    b5.mode  = m;
    b5.x     = xv;
    b5.e     = ev;
    @(posedge clk);
    #1;
    b5.start = 1'b0;
    lat = 0;
    while (lat < 300 && !b5.done) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done5 reached", {63'b0, b5.done}, 64'd1);
    r  = b5.result;
    er = b5.err;
  endtask

  task automatic run8(input logic m, input logic [7:0] xv, input logic [7:0] ev,
                      output logic [7:0] r, output logic er, output int lat);
    @(negedge clk);
    b8.start = 1'b1;
    b8.mode  = m;
    b8.x     = xv;
    b8.e     = ev;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    lat = 0;
    while (lat < 600 && !b8.done) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done8 reached", {63'b0, b8.done}, 64'd1);
    r  = b8.result;
    er = b8.err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] r5;
    logic [7:0] r8;
    logic       er;
    int         lat, pop, ndone, cyc, first, second, l5;

    // p = 31; mode 1 means exponent 29.
    v5[0]  = '{1'b1, 5'd3,  5'd0,  5'd21, 1'b0};
    v5[1]  = '{1'b0, 5'd3,  5'd4,  5'd19, 1'b0};
    v5[2]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1};
    v5[3]  = '{1'b0, 5'd0,  5'd0,  5'd1,  1'b0};
    v5[4]  = '{1'b0, 5'd2,  5'd5,  5'd1,  1'b0};
    v5[5]  = '{1'b0, 5'd31, 5'd5,  5'd0,  1'b0};
    v5[6]  = '{1'b1, 5'd31, 5'd7,  5'd0,  1'b1};
    v5[7]  = '{1'b0, 5'd30, 5'd31, 5'd30, 1'b0};
    v5[8]  = '{1'b0, 5'd7,  5'd1,  5'd7,  1'b0};
    v5[9]  = '{1'b1, 5'd1,  5'd0,  5'd1,  1'b0};
    v5[10] = '{1'b1, 5'd30, 5'd0,  5'd30, 1'b0};
    v5[11] = '{1'b0, 5'd5,  5'd3,  5'd1,  1'b0};
    v5[12] = '{1'b1, 5'd5,  5'd31, 5'd25, 1'b0};
    v5[13] = '{1'b0, 5'd3,  5'd31, 5'd3,  1'b0};

    // p = 251; mode 1 means exponent 249.
    v8[0] = '{1'b1, 8'd5,   8'd0,   8'd201, 1'b0};
    v8[1] = '{1'b1, 8'd255, 8'd0,   8'd63,  1'b0};
    v8[2] = '{1'b0, 8'd250, 8'd2,   8'd1,   1'b0};
    v8[3] = '{1'b1, 8'd251, 8'd0,   8'd0,   1'b1};
    v8[4] = '{1'b0, 8'd2,   8'd7,   8'd128, 1'b0};
    v8[5] = '{1'b0, 8'd3,   8'd5,   8'd243, 1'b0};
    v8[6] = '{1'b0, 8'd16,  8'd2,   8'd5,   1'b0};
    v8[7] = '{1'b0, 8'd250, 8'd255, 8'd250, 1'b0};

    b5.start = 1'b0; b5.mode = 1'b0; b5.x = '0; b5.e = '0;
    b8.start = 1'b0; b8.mode = 1'b0; b8.x = '0; b8.e = '0;

    #1 rst = 1'b1;
    #11;
    chk("reset busy5", {63'b0, b5.busy}, 64'd0);
    chk("reset done5", {63'b0, b5.done}, 64'd0);
    chk("reset err5", {63'b0, b5.err}, 64'd0);
    chk("reset result5", {59'b0, b5.result}, 64'd0);
    chk("reset busy8", {63'b0, b8.busy}, 64'd0);
    chk("reset result8", {56'b0, b8.result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run5(v5[i].mode, v5[i].x, v5[i].e, r5, er, lat);
      pop = v5[i].mode ? $countones(5'd29) : $countones(v5[i].e);
      chk($sformatf("v5[%0d] result", i), {59'b0, r5}, {59'b0, v5[i].res});
      chk($sformatf("v5[%0d] err", i), {63'b0, er}, {63'b0, v5[i].err});
      chk($sformatf("v5[%0d] latency", i), 64'(lat), 64'(lat_exp(5, 5, pop)));
    end

    for (int i = 0; i < 8; i++) begin
      run8(v8[i].mode, v8[i].x, v8[i].e, r8, er, lat);
      pop = v8[i].mode ? $countones(8'd249) : $countones(v8[i].e);
      chk($sformatf("v8[%0d] result", i), {56'b0, r8}, {56'b0, v8[i].res});
      chk($sformatf("v8[%0d] err", i), {63'b0, er}, {63'b0, v8[i].err});
      chk($sformatf("v8[%0d] latency", i), 64'(lat), 64'(lat_exp(8, 8, pop)));
      if (v8[i].mode && !v8[i].err) begin
        chk($sformatf("v8[%0d] x*inv mod p", i),
            64'(((int'(v8[i].x) % 251) * int'(r8)) % 251), 64'd1);
      end
    end

    // start pulses during LOAD/SQR/MUL must be ignored.
    l5 = lat_exp(5, 5, 1);
    @(negedge clk);
    b5.start = 1'b1; b5.mode = 1'b0; b5.x = 5'd3; b5.e = 5'd4;
    @(posedge clk);
    #1;
    chk("busy after accept", {63'b0, b5.busy}, 64'd1);
    ndone = 0;
    for (int c = 1; c <= 150; c++) begin
      b5.start = (c == 1 || c == 5 || c == 6 || c == 20);
      b5.mode  = 1'b1;
      b5.x     = 5'd7;
      @(posedge clk);
      #1;
      if (b5.done) ndone++;
    end
    b5.start = 1'b0;
    chk("busy-start done count", 64'(ndone), 64'd1);
    chk("busy-start result", {59'b0, b5.result}, 64'd19);
    chk("busy after done", {63'b0, b5.busy}, 64'd0);

    // start held high: FIN ignores it, the following idle cycle accepts it.
    @(negedge clk);
    b5.start = 1'b1; b5.mode = 1'b0; b5.x = 5'd3; b5.e = 5'd4;
    @(posedge clk);
    #1;
    cyc = 0; first = 0; second = 0;
    while (cyc < 400 && second == 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (b5.done) begin
        if (first == 0) first = cyc;
        else second = cyc;
      end
      if (first != 0 && cyc == first + 1) b5.start = 1'b0;
    end
    b5.start = 1'b0;
    chk("held-start first done", 64'(first), 64'(l5));
    chk("held-start second done", 64'(second), 64'(2 * l5 + 1));
    chk("held-start result", {59'b0, b5.result}, 64'd19);

    // Asynchronous reset in the middle of a squaring pass.
    @(negedge clk);
    b5.start = 1'b1; b5.mode = 1'b1; b5.x = 5'd3; b5.e = 5'd0;
    @(posedge clk);
    #1;
    b5.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("busy before reset", {63'b0, b5.busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid-op reset busy", {63'b0, b5.busy}, 64'd0);
    chk("mid-op reset done", {63'b0, b5.done}, 64'd0);
    chk("mid-op reset err", {63'b0, b5.err}, 64'd0);
    chk("mid-op reset result", {59'b0, b5.result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run5(1'b1, 5'd3, 5'd0, r5, er, lat);
    chk("post-reset result", {59'b0, r5}, 64'd21);
    chk("post-reset err", {63'b0, er}, 64'd0);
    chk("post-reset latency", 64'(lat), 64'(lat_exp(5, 5, 4)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
